// File: rtl/sdram_frame_writer.sv
// Drains a show-ahead pixel FIFO into SDRAM as fixed-length write bursts
// through the controller command port, wrapping the frame buffer at FRAME_WORDS.
module sdram_frame_writer #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 16,
  parameter int USED_WIDTH    = 5,
  parameter int BURST_LENGTH  = 8,
  parameter int FRAME_WORDS   = 307200,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_sync,
  input  logic [DATA_WIDTH-1:0]    fifo_data_out,
  input  logic [USED_WIDTH-1:0]    fifo_data_out_used,
  output logic                     fifo_data_out_acknowledge,
  output logic [1:0]               command,
  output logic [ADDRESS_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0]    data_write,
  input  logic                     data_write_done,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CNT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR  = ADDRESS_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(BASE_ADDRESS + FRAME_WORDS - 1);
  localparam logic [USED_WIDTH-1:0]    BURST_USED = USED_WIDTH'(BURST_LENGTH);
  localparam logic [CNT_W-1:0]         CNT_LOAD   = CNT_W'(BURST_LENGTH - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                   state_q;
  logic [1:0]               command_q;
  logic [ADDRESS_WIDTH-1:0] data_address_q;
  logic [DATA_WIDTH-1:0]    data_write_q;
  logic [CNT_W-1:0]         countdown_q;
  logic                     sync_pending_q;
  logic                     frame_done_q;
  logic                     busy_q;

  logic                     start_d;
  logic                     write_pop_d;
  logic                     wrap_d;
  logic [ADDRESS_WIDTH-1:0] address_next_d;

  // A pending sync takes priority over starting a burst, costing one idle cycle.
  assign start_d        = (state_q == IDLE) && !sync_pending_q && enable &&
                          (fifo_data_out_used >= BURST_USED);
  assign write_pop_d    = (state_q == WRITE) && data_write_done && (countdown_q != '0);
  assign wrap_d         = (data_address_q == LAST_ADDR);
  assign address_next_d = wrap_d ? BASE_ADDR : data_address_q + ADDRESS_WIDTH'(1);

  // Gated by reset so no word is popped in a cycle whose state is being discarded.
  assign fifo_data_out_acknowledge = !reset && (start_d || write_pop_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      command_q      <= 2'd0;
      data_address_q <= BASE_ADDR;
      data_write_q   <= '0;
      countdown_q    <= '0;
      sync_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_pending_q) begin
            data_address_q <= BASE_ADDR;
            sync_pending_q <= 1'b0;
          end else if (start_d) begin
            command_q    <= 2'd1;
            data_write_q <= fifo_data_out;
            countdown_q  <= CNT_LOAD;
            busy_q       <= 1'b1;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (data_write_done) begin
            data_address_q <= address_next_d;
            frame_done_q   <= wrap_d;
            if (countdown_q != '0) begin
              data_write_q <= fifo_data_out;
              countdown_q  <= countdown_q - CNT_W'(1);
            end else begin
              command_q <= 2'd0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new pulse re-arms the sync even in the cycle an older one is consumed.
      if (frame_sync) sync_pending_q <= 1'b1;
    end
  end

  assign command      = command_q;
  assign data_address = data_address_q;
  assign data_write   = data_write_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Scoreboard bench: FIFO and controller models drive the writer, a negedge
// monitor compares every presented write word against queued expectations.
module tb_sdram_frame_writer;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int UW = 5;
  localparam logic [AW-1:0] LAST = 22'd19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] fifo_head = '0;
  logic [UW-1:0] fifo_used = '0;
  logic          ack;
  logic [1:0]    command;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_write;
  logic          done = 1'b0;
  logic          busy;
  logic          frame_done;

  sdram_frame_writer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .USED_WIDTH(UW),
    .BURST_LENGTH(8), .FRAME_WORDS(20), .BASE_ADDRESS(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .fifo_data_out(fifo_head), .fifo_data_out_used(fifo_used),
    .fifo_data_out_acknowledge(ack), .command(command),
    .data_address(data_address), .data_write(data_write),
    .data_write_done(done), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] fifo_m[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            pop_cnt = 0;
  int            acc_cnt = 0;
  int            fd_cnt = 0;
  int            gap = 0;
  logic          fd_exp = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out / unexpected event", name);
  endfunction

  function automatic void fifo_refresh();
    fifo_used = UW'(fifo_m.size());
    fifo_head = (fifo_m.size() != 0) ? fifo_m[0] : '0;
  endfunction

  function automatic void fifo_push(logic [DW-1:0] w);
    fifo_m.push_back(w);
    fifo_refresh();
  endfunction

  function automatic void exp_push(int a, int d);
    wr_t e;
    e.a = AW'(a);
    e.d = DW'(d);
    exp_q.push_back(e);
  endfunction

  // FIFO model: pops take effect just after the edge that saw the acknowledge.
  initial begin
    logic pop;
    forever begin
      @(posedge clk);
      pop = ack;
      #1;
      if (pop) begin
        if (fifo_m.size() == 0) fail_now("pop_empty");
        else begin
          void'(fifo_m.pop_front());
          pop_cnt++;
        end
        fifo_refresh();
      end
    end
  end

  // Controller model: accepts a word, then stays silent for 'gap' cycles.
  initial begin
    int gcnt;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || command != 2'd1) begin
        done = 1'b0;
        gcnt = 0;
      end else if (!done) begin
        if (gcnt >= gap) begin
          done = 1'b1;
          gcnt = 0;
        end else gcnt++;
      end else if (gap != 0) begin
        done = 1'b0;
        gcnt = 1;
      end
    end
  end

  // Monitor: every cycle a write is presented it must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fd_exp || frame_done) chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        if (command == 2'd1) begin
          if (exp_q.size() == 0) fail_now("unexpected_write");
          else begin
            chk("wr_addr", 32'(data_address), 32'(exp_q[0].a));
            chk("wr_data", 32'(data_write), 32'(exp_q[0].d));
            chk("busy", 32'(busy), 32'd1);
            if (done) begin
              fd_exp = (exp_q[0].a == LAST);
              void'(exp_q.pop_front());
              acc_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && command == 2'd0) break;
    end
    if (k == 400) fail_now(name);
  endtask

  initial begin
    int idle;
    int k;
    int base;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_command", 32'(command), 32'd0);
    chk("rst_addr", 32'(data_address), 32'd0);
    chk("rst_data", 32'(data_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    step();
    reset = 1'b0;

    // One full burst of 0..7 at addresses 0..7
    step();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) exp_push(i, i);
    for (int i = 0; i < 8; i++) fifo_push(DW'(i));
    wait_drain("burst1_drain");
    chk("burst1_pops", 32'(pop_cnt), 32'd8);

    // Seven words are not enough; the eighth starts a burst with gapped dones
    gap = 3;
    step();
    for (int i = 8; i < 15; i++) fifo_push(DW'(i));
    repeat (5) @(negedge clk);
    chk("under_command", 32'(command), 32'd0);
    chk("under_ack", 32'(ack), 32'd0);
    chk("under_pops", 32'(pop_cnt), 32'd8);
    step();
    for (int i = 8; i < 16; i++) exp_push(i, i);
    fifo_push(16'h000F);
    @(negedge clk);
    chk("start_ack", 32'(ack), 32'd1);
    chk("start_cmd_pre", 32'(command), 32'd0);
    @(negedge clk);
    chk("start_cmd", 32'(command), 32'd1);
    wait_drain("burst2_drain");
    chk("burst2_pops", 32'(pop_cnt), 32'd16);
    chk("burst2_fifo_empty", 32'(fifo_m.size()), 32'd0);

    // Frame wrap: 24 words from address 16 wrap twice through 19
    gap = 0;
    step();
    for (int i = 0; i < 24; i++) exp_push((16 + i) % 20, 16'h0100 + i);
    for (int i = 0; i < 24; i++) fifo_push(DW'(16'h0100 + i));
    wait_drain("wrap_drain");
    chk("wrap_frame_done_count", 32'(fd_cnt), 32'd2);
    chk("wrap_pops", 32'(pop_cnt), 32'd40);

    // frame_sync mid-burst: finish at 7, sync idle cycle, next burst at 0
    step();
    for (int i = 0; i < 16; i++) exp_push(i % 8, 16'h0200 + i);
    for (int i = 0; i < 16; i++) fifo_push(DW'(16'h0200 + i));
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (command == 2'd1 && data_address == 22'd5) break;
    end
    if (k == 100) fail_now("sync_wait_addr5");
    step();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    idle = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (command == 2'd0) idle++;
      else if (idle > 0) break;
    end
    if (k == 100) fail_now("sync_wait_restart");
    chk("sync_idle_cycles", 32'(idle), 32'd2);
    wait_drain("sync_drain");
    chk("sync_pops", 32'(pop_cnt), 32'd56);

    // Reset after the third accepted word of a burst starting at address 8
    base = acc_cnt;
    step();
    for (int i = 0; i < 3; i++) exp_push(8 + i, 16'h0300 + i);
    for (int i = 0; i < 8; i++) fifo_push(DW'(16'h0300 + i));
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (acc_cnt == base + 3) break;
    end
    if (k == 100) fail_now("reset_wait_third");
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    @(negedge clk);
    chk("rst_mid_command", 32'(command), 32'd0);
    chk("rst_mid_addr", 32'(data_address), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_data", 32'(data_write), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_pops", 32'(pop_cnt), 32'd60);
    chk("rst_mid_fifo_left", 32'(fifo_m.size()), 32'd4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
